// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        DRAIN
    } arb_state_e;

    // Modular add for requester indices; a and b are always below n.
    function automatic int wrap_add(input int a, input int b, input int n);
        int s;
        s = a + b;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set request at or above rr_ptr, with wrap.
module rr_pick
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     rr_ptr,
    output logic [IDW-1:0]     grant_index,
    output logic               any
);

    always_comb begin
        int idx;
        grant_index = '0;
        any         = 1'b0;
        idx         = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = wrap_add(int'(rr_ptr), i, NUM_REQ);
            if (!any && req[idx]) begin
                any         = 1'b1;
                grant_index = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte producers,
// with per-grant packet locking capped at MAX_BURST bytes.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int  DATA_WIDTH = UART_DATA_WIDTH,
    parameter int  NUM_REQ    = 4,
    parameter int  MAX_BURST  = 16,
    localparam int IDW        = $clog2(NUM_REQ),
    localparam int BCW        = $clog2(MAX_BURST + 1)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [DATA_WIDTH-1:0] req_data [NUM_REQ],
    input  logic [NUM_REQ-1:0]    req_last,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [IDW-1:0]        grant_id,
    output logic                  busy
);

    arb_state_e            state_q;
    logic [IDW-1:0]        rr_ptr_q;
    logic [IDW-1:0]        grant_q;
    logic [BCW-1:0]        burst_q;
    logic                  last_q;
    logic [DATA_WIDTH-1:0] tx_data_q;
    logic                  tx_valid_q;

    logic [IDW-1:0]        pick_idx;
    logic                  pick_any;
    logic [IDW-1:0]        ptr_next_d;
    logic [BCW-1:0]        burst_d;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr_pick (
        .req         (req_valid),
        .rr_ptr      (rr_ptr_q),
        .grant_index (pick_idx),
        .any         (pick_any)
    );

    // Priority always rotates to the requester just past the one released.
    assign ptr_next_d = IDW'(wrap_add(int'(grant_q), 1, NUM_REQ));
    assign burst_d    = burst_q + BCW'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            burst_q    <= '0;
            last_q     <= 1'b0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        grant_q <= pick_idx;
                        burst_q <= '0;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    if (req_valid[grant_q]) begin
                        tx_data_q  <= req_data[grant_q];
                        last_q     <= req_last[grant_q];
                        tx_valid_q <= 1'b1;
                        state_q    <= SEND;
                    end else begin
                        rr_ptr_q <= ptr_next_d;
                        state_q  <= IDLE;
                    end
                end
                SEND: begin
                    // tx_ready falling is the transmitter's acceptance of the byte.
                    if (!tx_ready) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (tx_ready) begin
                        burst_q <= burst_d;
                        if (last_q || burst_d == BCW'(MAX_BURST)) begin
                            rr_ptr_q <= ptr_next_d;
                            state_q  <= IDLE;
                        end else begin
                            state_q <= LOAD;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == LOAD) begin
            req_ready[grant_q] = req_valid[grant_q];
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign grant_id = grant_q;
    assign busy     = (state_q != IDLE);

endmodule
